// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: IFU and LSU request/response channels plus the
// shared multicycle memory port. master = arbiter side, slave = requesters+memory.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // IFU channel
  logic              ifu_req_valid;
  logic              ifu_req_ready;
  logic [ADDR_W-1:0] ifu_addr;
  logic              ifu_resp_valid;
  logic              ifu_resp_ready;
  logic [DATA_W-1:0] ifu_rdata;
  logic              ifu_resp_err;
  // LSU channel
  logic              lsu_req_valid;
  logic              lsu_req_ready;
  logic              lsu_wen;
  logic [ADDR_W-1:0] lsu_addr;
  logic [DATA_W-1:0] lsu_wdata;
  logic [7:0]        lsu_wmask;
  logic [2:0]        lsu_readop;
  logic              lsu_resp_valid;
  logic              lsu_resp_ready;
  logic [DATA_W-1:0] lsu_rdata;
  logic              lsu_resp_err;
  // memory port
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [7:0]        mem_wmask;
  logic [2:0]        mem_readop;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  ifu_req_valid, ifu_addr, ifu_resp_ready,
    input  lsu_req_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask, lsu_readop, lsu_resp_ready,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
    output mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask, mem_readop
  );

  modport slave (
    output ifu_req_valid, ifu_addr, ifu_resp_ready,
    output lsu_req_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask, lsu_readop, lsu_resp_ready,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
    input  mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask, mem_readop
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (IFU, LSU) arbiter for a single multicycle memory port.
// One access in flight: IDLE -> REQ -> WAIT -> RESP -> IDLE, with a watchdog
// in WAIT that turns a hung access into an error response.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter bit RR_EN   = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  localparam int                CW      = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]     TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEADBEEF);

  state_e            state_q;
  logic              own_lsu_q;   // owner of the in-flight access
  logic              last_lsu_q;  // owner of the last completed access
  logic              wen_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [7:0]        wmask_q;
  logic [2:0]        readop_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cnt_d;

  logic grant_lsu, idle, ifu_rdy, lsu_rdy, resp_hs, in_resp;

  // Arbitration: a lone requester wins; on a tie round-robin favours the one
  // not served last, fixed priority favours the LSU.
  always_comb begin
    grant_lsu = bus.lsu_req_valid;
    if (bus.lsu_req_valid && bus.ifu_req_valid)
      grant_lsu = RR_EN ? ~last_lsu_q : 1'b1;
  end

  assign idle    = (state_q == IDLE) && rst_n;
  assign ifu_rdy = idle && bus.ifu_req_valid && !grant_lsu;
  assign lsu_rdy = idle && bus.lsu_req_valid && grant_lsu;
  assign in_resp = (state_q == RESP);
  assign resp_hs = in_resp && (own_lsu_q ? bus.lsu_resp_ready : bus.ifu_resp_ready);
  assign cnt_d   = cnt_q + CW'(1);

  // Access sequencer: latch winner, drive memory, watch for response/timeout,
  // hold the response until the owner takes it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      own_lsu_q  <= 1'b0;
      last_lsu_q <= 1'b0;
      wen_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      readop_q   <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (lsu_rdy) begin
            own_lsu_q <= 1'b1;
            wen_q     <= bus.lsu_wen;
            addr_q    <= bus.lsu_addr;
            wdata_q   <= bus.lsu_wdata;
            wmask_q   <= bus.lsu_wmask;
            readop_q  <= bus.lsu_readop;
            state_q   <= REQ;
          end else if (ifu_rdy) begin
            own_lsu_q <= 1'b0;
            wen_q     <= 1'b0;
            addr_q    <= bus.ifu_addr;
            wdata_q   <= '0;
            wmask_q   <= '0;
            readop_q  <= 3'h2;  // instruction fetch is always a word
            state_q   <= REQ;
          end
        end
        REQ: begin
          if (bus.mem_req_ready) begin
            cnt_q   <= '0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          // a response in the timeout cycle still counts as a normal response
          if (bus.mem_resp_valid) begin
            rdata_q <= wen_q ? '0 : bus.mem_rdata;
            err_q   <= 1'b0;
            state_q <= RESP;
          end else if (cnt_q == TO_LAST) begin
            rdata_q <= ERR_DATA;
            err_q   <= 1'b1;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        RESP: begin
          // service is credited only here, so a timeout still advances the pointer
          if (resp_hs) begin
            last_lsu_q <= own_lsu_q;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ifu_req_ready  = ifu_rdy;
  assign bus.lsu_req_ready  = lsu_rdy;

  assign bus.mem_req_valid  = (state_q == REQ);
  assign bus.mem_wen        = wen_q;
  assign bus.mem_addr       = addr_q;
  assign bus.mem_wdata      = wdata_q;
  assign bus.mem_wmask      = wmask_q;
  assign bus.mem_readop     = readop_q;

  // only the owner's response channel is ever non-zero
  assign bus.ifu_resp_valid = in_resp && !own_lsu_q;
  assign bus.ifu_rdata      = (in_resp && !own_lsu_q) ? rdata_q : '0;
  assign bus.ifu_resp_err   = in_resp && !own_lsu_q && err_q;
  assign bus.lsu_resp_valid = in_resp && own_lsu_q;
  assign bus.lsu_rdata      = (in_resp && own_lsu_q) ? rdata_q : '0;
  assign bus.lsu_resp_err   = in_resp && own_lsu_q && err_q;
endmodule
